// File: rtl/hotstate_sequencer.sv
// Microcode address sequencer: program address register plus subroutine/interrupt
// return stack, with interrupt > return > call > jump > fall-through priority.
module hotstate_sequencer #(
  parameter int                   ADR_WIDTH   = 8,
  parameter int                   STACK_DEPTH = 4,
  parameter logic [ADR_WIDTH-1:0] RESET_ADR   = '0,
  parameter logic [ADR_WIDTH-1:0] INT_VECTOR  = ADR_WIDTH'(1),
  localparam int                  LW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 jadr,
  input  logic [ADR_WIDTH-1:0] jump_adr,
  input  logic                 sub_push,
  input  logic                 sub_pop,
  input  logic                 fired,
  input  logic                 clear_err,
  output logic [ADR_WIDTH-1:0] adr,
  output logic [LW-1:0]        stack_level,
  output logic                 stack_empty,
  output logic                 stack_full,
  output logic                 int_pending,
  output logic                 overflow,
  output logic                 underflow
);

  logic [ADR_WIDTH-1:0] adr_q, adr_d, adr_inc, top, push_val;
  logic [LW-1:0]        lvl_q, lvl_d;
  logic                 pend_q, pend_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                 push_req, new_ovf, new_unf, wr_en, empty, full;
  logic [ADR_WIDTH-1:0] stack_q [STACK_DEPTH];

  assign adr_inc = adr_q + ADR_WIDTH'(1);
  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == LW'(STACK_DEPTH));

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (lvl_q == LW'(i + 1)) top = stack_q[i];
  end

  always_comb begin
    adr_d    = adr_q;
    lvl_d    = lvl_q;
    pend_d   = pend_q;
    push_req = 1'b0;
    push_val = adr_inc;
    new_ovf  = 1'b0;
    new_unf  = 1'b0;
    if (hold) begin
      pend_d = pend_q | fired;
    end else if (fired | pend_q) begin
      // Push the interrupted address itself so it re-executes on return.
      push_req = 1'b1;
      push_val = adr_q;
      adr_d    = INT_VECTOR;
      pend_d   = 1'b0;
    end else if (sub_pop) begin
      if (empty) begin
        new_unf = 1'b1;
        adr_d   = adr_inc;
      end else begin
        adr_d = top;
        lvl_d = lvl_q - LW'(1);
      end
    end else if (jadr) begin
      adr_d    = jump_adr;
      push_req = sub_push;
    end else begin
      adr_d = adr_inc;
    end
    if (push_req) begin
      if (full) new_ovf = 1'b1;
      else      lvl_d   = lvl_q + LW'(1);
    end
    wr_en = push_req & ~full;
    ovf_d = (ovf_q & ~clear_err) | new_ovf;
    unf_d = (unf_q & ~clear_err) | new_unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q  <= RESET_ADR;
      lvl_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      adr_q  <= adr_d;
      lvl_q  <= lvl_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Stack contents need no reset; only the level qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (wr_en && lvl_q == LW'(i)) stack_q[i] <= push_val;
  end

  assign adr         = adr_q;
  assign stack_level = lvl_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign int_pending = pend_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_hotstate_sequencer.sv
// Scoreboard bench for hotstate_sequencer: directed test-plan scenarios followed
// by random traffic, all checked against a queue-based reference model.
module tb_hotstate_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, hold, jadr, sub_push, sub_pop, fired, clear_err;
  logic [7:0] jump_adr;
  logic [7:0] adr;
  logic [2:0] stack_level;
  logic       stack_empty, stack_full, int_pending, overflow, underflow;

  hotstate_sequencer #(.ADR_WIDTH(8), .STACK_DEPTH(DEPTH), .RESET_ADR(8'h00), .INT_VECTOR(8'h01)) dut (
    .clk(clk), .rst(rst), .hold(hold), .jadr(jadr), .jump_adr(jump_adr),
    .sub_push(sub_push), .sub_pop(sub_pop), .fired(fired), .clear_err(clear_err),
    .adr(adr), .stack_level(stack_level), .stack_empty(stack_empty), .stack_full(stack_full),
    .int_pending(int_pending), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct { int adr; int lvl; bit pend; bit ovf; bit unf; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int m_adr = 0;
  int m_stk[$];
  bit m_pend = 0, m_ovf = 0, m_unf = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(bit r, bit h, bit j, int ja, bit p, bit po, bit f, bit c);
    bit want_push = 0, nov = 0, nun = 0;
    int pv = 0;
    if (r) begin
      m_adr = 0; m_stk.delete(); m_pend = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (h) begin
      m_pend = m_pend | f;
    end else if (f || m_pend) begin
      want_push = 1; pv = m_adr; m_adr = 1; m_pend = 0;
    end else if (po) begin
      if (m_stk.size() == 0) begin nun = 1; m_adr = (m_adr + 1) % 256; end
      else m_adr = m_stk.pop_back();
    end else if (p && j) begin
      want_push = 1; pv = (m_adr + 1) % 256; m_adr = ja;
    end else if (j) begin
      m_adr = ja;
    end else begin
      m_adr = (m_adr + 1) % 256;
    end
    if (want_push) begin
      if (m_stk.size() == DEPTH) nov = 1;
      else m_stk.push_back(pv);
    end
    m_ovf = (m_ovf && !c) || nov;
    m_unf = (m_unf && !c) || nun;
  endfunction

  task automatic cyc(input bit r, input bit h, input bit j, input logic [7:0] ja,
                     input bit p, input bit po, input bit f, input bit c);
    exp_t e;
    @(negedge clk);
    rst = r; hold = h; jadr = j; jump_adr = ja; sub_push = p; sub_pop = po; fired = f; clear_err = c;
    model_step(r, h, j, int'(ja), p, po, f, c);
    e.adr = m_adr; e.lvl = m_stk.size(); e.pend = m_pend; e.ovf = m_ovf; e.unf = m_unf;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic idle_to(input int target);
    for (int i = 0; i < 300 && m_adr != target; i++) cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  // Monitor: one expected entry per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp("adr", adr, e.adr);
        cmp("stack_level", stack_level, e.lvl);
        cmp("stack_empty", stack_empty, e.lvl == 0);
        cmp("stack_full", stack_full, e.lvl == DEPTH);
        cmp("int_pending", int_pending, e.pend);
        cmp("overflow", overflow, e.ovf);
        cmp("underflow", underflow, e.unf);
      end
    end
  end

  initial begin
    int r, h, j, p, po, f, c;
    rst = 1; hold = 0; jadr = 0; jump_adr = 0; sub_push = 0; sub_pop = 0; fired = 0; clear_err = 0;

    // Reset then fall-through with wrap
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
    settle(); cmp("reset_adr", adr, 0);
    idle(300);
    settle(); cmp("wrap_adr", adr, 44);

    // Call / return
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
    idle_to(8'h10);
    cyc(0, 0, 1, 8'h40, 1, 0, 0, 0);
    settle(); cmp("call_adr", adr, 8'h40); cmp("call_level", stack_level, 1);
    idle(2);
    cyc(0, 0, 0, 8'h00, 0, 1, 0, 0);
    settle(); cmp("ret_adr", adr, 8'h11); cmp("ret_level", stack_level, 0);

    // Interrupt beats a coincident call
    idle_to(8'h20);
    cyc(0, 0, 1, 8'h80, 1, 0, 1, 0);
    settle(); cmp("int_adr", adr, 8'h01); cmp("int_level", stack_level, 1);
    cyc(0, 0, 0, 8'h00, 0, 1, 0, 0);
    settle(); cmp("int_ret_adr", adr, 8'h20);

    // Interrupt latched under hold
    idle_to(8'h30);
    cyc(0, 1, 0, 8'h00, 0, 0, 1, 0);
    settle(); cmp("hold_adr", adr, 8'h30); cmp("hold_pend", int_pending, 1);
    cyc(0, 1, 1, 8'h99, 1, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
    settle(); cmp("rel_adr", adr, 8'h01); cmp("rel_pend", int_pending, 0);
    cyc(0, 0, 0, 8'h00, 0, 1, 0, 0);
    settle(); cmp("rel_ret_adr", adr, 8'h30);

    // Overflow
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h50, 1, 0, 0, 0);
    settle(); cmp("ovf_adr", adr, 8'h50); cmp("ovf_level", stack_level, 4);
    cmp("ovf_full", stack_full, 1); cmp("ovf_flag", overflow, 1);
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 1);
    settle(); cmp("ovf_clear", overflow, 0);

    // Underflow, then reset mid-call
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
    idle_to(8'h05);
    cyc(0, 0, 0, 8'h00, 0, 1, 0, 0);
    settle(); cmp("unf_adr", adr, 8'h06); cmp("unf_flag", underflow, 1); cmp("unf_level", stack_level, 0);
    cyc(0, 0, 1, 8'h60, 1, 0, 0, 0);
    cyc(0, 0, 1, 8'h70, 1, 0, 0, 0);
    cyc(1, 0, 1, 8'h80, 1, 0, 0, 0);
    settle(); cmp("rst_adr", adr, 0); cmp("rst_level", stack_level, 0); cmp("rst_unf", underflow, 0);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      r  = ($urandom_range(63) == 0);
      h  = ($urandom_range(3) == 0);
      j  = ($urandom_range(2) == 0);
      p  = ($urandom_range(2) == 0);
      po = ($urandom_range(4) == 0);
      f  = ($urandom_range(15) == 0);
      c  = ($urandom_range(7) == 0);
      cyc(r[0], h[0], j[0], 8'($urandom), p[0], po[0], f[0], c[0]);
    end

    cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    cmp("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/hotstate_sequencer.md
Name: hotstate_sequencer

Overview:
- Microcode address sequencer for the hotstate engine; consumes the branch decisions (jadr, sub_push, sub_pop, fired) produced by the control block.
- Owns the program address register and the subroutine/interrupt return stack.
- Resolves priority between interrupt entry, return, call, jump and fall-through, and handles stall via hold.
- Drives adr to the microcode memory every cycle.

Parameters:
ADR_WIDTH, 8, width of microcode address
STACK_DEPTH, 4, number of return-stack entries (>=1)
RESET_ADR, 0, address loaded on reset
INT_VECTOR, 1, address loaded on interrupt entry

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
hold  in  1  stall; freezes adr and stack
jadr  in  1  take jump to jump_adr
jump_adr  in  ADR_WIDTH  jump/call target from microcode word
sub_push  in  1  push return address (call or interrupt)
sub_pop  in  1  return: load top of stack and pop
fired  in  1  one-cycle interrupt-entry pulse
clear_err  in  1  clears sticky error flags
adr  out  ADR_WIDTH  current microcode address
stack_level  out  $clog2(STACK_DEPTH+1)  entries in use
stack_empty  out  1  stack_level==0
stack_full  out  1  stack_level==STACK_DEPTH
int_pending  out  1  interrupt latched during hold, not yet serviced
overflow  out  1  sticky: push attempted when full
underflow  out  1  sticky: pop attempted when empty

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on rising clk.
  - rst=1 synchronously sets adr=RESET_ADR, stack_level=0, int_pending=0, overflow=0, underflow=0. Stack contents are don't-care.
  - rst has priority over every other input, including mid-call or mid-hold.
- Interrupt request: int_req = fired | int_pending.
- hold=1:
  - adr, stack and stack_level are unchanged; jadr, sub_push and sub_pop are ignored.
  - fired=1 during hold sets int_pending=1.
- hold=0: the next address is selected by strict priority:
  1. int_req (interrupt entry): push current adr, so the interrupted instruction re-executes on return. Set adr=INT_VECTOR and clear int_pending. sub_push/sub_pop/jadr are ignored that cycle; a coincident sub_pop is dropped and the return instruction re-executes later.
  2. sub_pop (return): adr=stack top, stack_level-1. Any sub_push or jadr in the same cycle is ignored.
  3. sub_push & jadr (call): push adr+1 (mod 2^ADR_WIDTH), adr=jump_adr.
  4. jadr: adr=jump_adr. The stack is untouched.
  5. Otherwise: adr=adr+1, wrapping from 2^ADR_WIDTH-1 to 0.
  - sub_push without jadr and without int_req: treated as case 5, no push.
- Stack:
  - LIFO of ADR_WIDTH-bit entries, read top combinationally.
  - Push when full: the push is dropped (contents and level unchanged), overflow=1, and the address change still happens.
  - Pop when empty: underflow=1, adr=adr+1, stack_level stays 0.
- Error flags:
  - overflow and underflow stay set until clear_err=1 or rst.
  - If clear_err coincides with a new error, the flag ends up set.
- Outputs and latency:
  - All outputs are registered or derived from registers only; there are no combinational paths from inputs to outputs.
  - adr reflects a decision one cycle after that decision's inputs are sampled.

Test Plan:
- Reset/fall-through: rst 1 cycle, then 300 idle cycles with ADR_WIDTH=8 -> adr=0,1,2,…, wraps 255->0; stack_level=0; flags=0.
- Call/return: at adr=0x10 assert sub_push=1, jadr=1, jump_adr=0x40 -> adr=0x40, stack_level=1. Two cycles later (adr=0x42) pulse sub_pop -> adr=0x11, stack_level=0.
- Interrupt during call: at adr=0x20 pulse fired together with sub_push=1, jadr=1, jump_adr=0x80 -> adr=0x01, top=0x20, level=1. Next cycle sub_pop -> adr=0x20.
- Interrupt under hold: hold=1 at adr=0x30, pulse fired -> int_pending=1, adr stays 0x30. Release hold -> adr=0x01, int_pending=0, top=0x30.
- Overflow: 5 consecutive calls to 0x50 with STACK_DEPTH=4 -> level=4, stack_full=1, 5th push dropped, overflow=1, adr=0x50. clear_err -> overflow=0.
- Underflow: sub_pop at adr=0x05 with an empty stack -> adr=0x06, underflow=1, level=0. rst mid-call (level=2) -> adr=0, level=0, underflow=0.
